// File: rtl/alu_cmd_sequencer_if.sv
// Command / ALU / result bundle between an upstream source, alu_cmd_sequencer and custom_alu.
// Optional macro ALU_CHAIN_EN adds the CMD_CHAIN input.
interface alu_cmd_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int OPW   = 4,
   parameter int CNT_W = 16
);
   logic             CMD_VALID;
   logic             CMD_READY;
   logic [OPW-1:0]   CMD_OP;
   logic [WIDTH-1:0] CMD_A;
   logic [WIDTH-1:0] CMD_B;
`ifdef ALU_CHAIN_EN
   logic             CMD_CHAIN;
`endif
   logic [OPW-1:0]   ALU_OP;
   logic [WIDTH-1:0] ALU_A;
   logic [WIDTH-1:0] ALU_B;
   logic [WIDTH-1:0] ALU_Z;
   logic             RES_VALID;
   logic             RES_READY;
   logic [WIDTH-1:0] RES_Z;
   logic [OPW-1:0]   RES_OP;
   logic             RES_ERR;
   logic             BUSY;
   logic [CNT_W-1:0] DONE_CNT;

   // Environment side: command source, ALU model and result sink.
   modport master (
`ifdef ALU_CHAIN_EN
      output CMD_CHAIN,
`endif
      output CMD_VALID, CMD_OP, CMD_A, CMD_B, ALU_Z, RES_READY,
      input  CMD_READY, ALU_OP, ALU_A, ALU_B, RES_VALID, RES_Z, RES_OP,
             RES_ERR, BUSY, DONE_CNT
   );

   // Sequencer side.
   modport slave (
`ifdef ALU_CHAIN_EN
      input  CMD_CHAIN,
`endif
      input  CMD_VALID, CMD_OP, CMD_A, CMD_B, ALU_Z, RES_READY,
      output CMD_READY, ALU_OP, ALU_A, ALU_B, RES_VALID, RES_Z, RES_OP,
             RES_ERR, BUSY, DONE_CNT
   );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Registers one command onto custom_alu inputs, waits SETTLE_CYCLES, captures Z and hands it off.
// Optional macro ALU_CHAIN_EN: CMD_CHAIN=1 feeds the last good result into ALU_B.
module alu_cmd_sequencer #(
   parameter int WIDTH         = 8,
   parameter int OPW           = 4,
   parameter int NUM_OPS       = 10,
   parameter int SETTLE_CYCLES = 1,   // legal range 1..15
   parameter int CNT_W         = 16
) (
   input logic                clk,
   input logic                rst,
   alu_cmd_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SETTLE, RESULT} state_t;

   localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES);
   localparam logic [OPW:0]     OP_LIMIT    = (OPW+1)'(NUM_OPS);
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [3:0]       settle_cnt;
   logic             illegal;
   logic             accept, capture, handshake;
   logic [WIDTH-1:0] operand_b;

   assign bus.CMD_READY = (state == IDLE) && !rst;
   assign bus.BUSY      = (state != IDLE);

   assign accept    = bus.CMD_VALID && bus.CMD_READY;
   // The counter reaches zero on the edge where it currently holds one.
   assign capture   = (state == SETTLE) && (settle_cnt == 4'd1);
   assign handshake = (state == RESULT) && bus.RES_VALID && bus.RES_READY;

`ifdef ALU_CHAIN_EN
   logic [WIDTH-1:0] last_z;
   assign operand_b = bus.CMD_CHAIN ? last_z : bus.CMD_B;
`else
   assign operand_b = bus.CMD_B;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept)    state_nxt = SETTLE;
         SETTLE:  if (capture)   state_nxt = RESULT;
         RESULT:  if (handshake) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.ALU_OP    <= '0;
         bus.ALU_A     <= '0;
         bus.ALU_B     <= '0;
         bus.RES_VALID <= 1'b0;
         bus.RES_Z     <= '0;
         bus.RES_OP    <= '0;
         bus.RES_ERR   <= 1'b0;
         bus.DONE_CNT  <= '0;
         settle_cnt    <= '0;
         illegal       <= 1'b0;
`ifdef ALU_CHAIN_EN
         last_z        <= '0;
`endif
      end else begin
         if (accept) begin
            bus.ALU_OP <= bus.CMD_OP;
            bus.ALU_A  <= bus.CMD_A;
            bus.ALU_B  <= operand_b;
            illegal    <= ({1'b0, bus.CMD_OP} >= OP_LIMIT);
            settle_cnt <= SETTLE_INIT;
         end else if (state == SETTLE) begin
            settle_cnt <= settle_cnt - 4'd1;
         end

         if (capture) begin
            bus.RES_Z     <= illegal ? '0 : bus.ALU_Z;
            bus.RES_OP    <= bus.ALU_OP;
            bus.RES_ERR   <= illegal;
            bus.RES_VALID <= 1'b1;
         end

         if (handshake) begin
            bus.RES_VALID <= 1'b0;
            bus.DONE_CNT  <= bus.DONE_CNT + CNT_ONE;
`ifdef ALU_CHAIN_EN
            if (!bus.RES_ERR) last_z <= bus.RES_Z;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: vector table, hand sequences, randomized traffic.
// A second instance with CNT_W=2 shadows the same stimulus to check counter wrap.
module tb_alu_cmd_sequencer;

   localparam int SETTLE = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_cmd_sequencer_if #(.WIDTH(8), .OPW(4), .CNT_W(16)) bus ();
   alu_cmd_sequencer_if #(.WIDTH(8), .OPW(4), .CNT_W(2))  bus2 ();

   alu_cmd_sequencer #(.WIDTH(8), .OPW(4), .NUM_OPS(10), .SETTLE_CYCLES(SETTLE), .CNT_W(16))
      dut (.clk(clk), .rst(rst), .bus(bus));
   alu_cmd_sequencer #(.WIDTH(8), .OPW(4), .NUM_OPS(10), .SETTLE_CYCLES(SETTLE), .CNT_W(2))
      dut2 (.clk(clk), .rst(rst), .bus(bus2));

   // ALU stubs: Z = A ^ B.
   assign bus.ALU_Z      = bus.ALU_A ^ bus.ALU_B;
   assign bus2.ALU_Z     = bus2.ALU_A ^ bus2.ALU_B;
   assign bus2.CMD_VALID = bus.CMD_VALID;
   assign bus2.CMD_OP    = bus.CMD_OP;
   assign bus2.CMD_A     = bus.CMD_A;
   assign bus2.CMD_B     = bus.CMD_B;
   assign bus2.RES_READY = bus.RES_READY;
`ifdef ALU_CHAIN_EN
   assign bus2.CMD_CHAIN = bus.CMD_CHAIN;
`endif

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] z;
      logic       err;
      int         bp;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   int         model_cnt = 0;
   logic [7:0] last_z = 8'h00;
   logic [3:0] exp_op;
   logic [7:0] exp_a, exp_b, exp_z;
   logic       exp_err;
   vec_t       vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: legal opcodes 0..9 produce A ^ B_eff, others produce 0 with the error flag.
   function automatic logic [8:0] ref_result(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b_eff);
      if (op >= 4'd10) return {1'b1, 8'h00};
      return {1'b0, a ^ b_eff};
   endfunction

   function automatic logic [7:0] eff_b(input logic [7:0] b, input logic chain);
`ifdef ALU_CHAIN_EN
      if (chain) return last_z;
`endif
      if (chain) return b;
      return b;
   endfunction

   task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic chain);
      bus.CMD_OP = op;
      bus.CMD_A  = a;
      bus.CMD_B  = b;
`ifdef ALU_CHAIN_EN
      bus.CMD_CHAIN = chain;
`endif
      if (chain) bus.CMD_VALID = 1'b1;
      bus.CMD_VALID = 1'b1;
   endtask

   // Called at the negedge just before the accepting edge.
   task automatic accept_check();
      @(negedge clk);
      bus.CMD_VALID = 1'b0;
      check("alu_op", 32'(bus.ALU_OP), 32'(exp_op));
      check("alu_a", 32'(bus.ALU_A), 32'(exp_a));
      check("alu_b", 32'(bus.ALU_B), 32'(exp_b));
      check("busy_after_accept", 32'(bus.BUSY), 32'd1);
   endtask

   task automatic start_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic chain, input logic [7:0] z, input logic err);
      int n = 0;
      @(negedge clk);
      while (!bus.CMD_READY && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.CMD_READY) check("cmd_ready_timeout", 32'(bus.CMD_READY), 32'd1);
      exp_op  = op;
      exp_a   = a;
      exp_b   = eff_b(b, chain);
      exp_z   = z;
      exp_err = err;
      drive(op, a, b, chain);
      accept_check();
   endtask

   task automatic wait_result();
      int lat = 0;
      while (!bus.RES_VALID && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'(SETTLE));
      check("res_z", 32'(bus.RES_Z), 32'(exp_z));
      check("res_op", 32'(bus.RES_OP), 32'(exp_op));
      check("res_err", 32'(bus.RES_ERR), 32'(exp_err));
      check("cmd_ready_in_result", 32'(bus.CMD_READY), 32'd0);
   endtask

   task automatic finish_cmd();
      bus.RES_READY = 1'b1;
      @(negedge clk);
      model_cnt++;
      if (!exp_err) last_z = exp_z;
      check("res_valid_drop", 32'(bus.RES_VALID), 32'd0);
      check("done_cnt", 32'(bus.DONE_CNT), 32'(model_cnt % 65536));
      check("done_cnt_w2", 32'(bus2.DONE_CNT), 32'(model_cnt % 4));
      check("cmd_ready_after", 32'(bus.CMD_READY), 32'd1);
   endtask

   task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic chain, input int bp, input logic [7:0] z, input logic err);
      bus.RES_READY = (bp == 0);
      start_cmd(op, a, b, chain, z, err);
      wait_result();
      repeat (bp) begin
         @(negedge clk);
         check("bp_valid", 32'(bus.RES_VALID), 32'd1);
         check("bp_z", 32'(bus.RES_Z), 32'(exp_z));
      end
      finish_cmd();
   endtask

   initial begin
      vecs[0] = '{op: 4'h1, a: 8'hF0, b: 8'h0F, z: 8'hFF, err: 1'b0, bp: 0};
      vecs[1] = '{op: 4'hC, a: 8'h55, b: 8'hAA, z: 8'h00, err: 1'b1, bp: 0};
      vecs[2] = '{op: 4'h9, a: 8'h3C, b: 8'hC3, z: 8'hFF, err: 1'b0, bp: 2};
      vecs[3] = '{op: 4'hA, a: 8'h01, b: 8'h02, z: 8'h00, err: 1'b1, bp: 0};
      vecs[4] = '{op: 4'h0, a: 8'hAA, b: 8'hAA, z: 8'h00, err: 1'b0, bp: 1};
      vecs[5] = '{op: 4'hF, a: 8'hFF, b: 8'h00, z: 8'h00, err: 1'b1, bp: 0};

      rst = 1'b1;
      bus.CMD_VALID = 1'b0;
      bus.CMD_OP = '0;
      bus.CMD_A = '0;
      bus.CMD_B = '0;
      bus.RES_READY = 1'b0;
`ifdef ALU_CHAIN_EN
      bus.CMD_CHAIN = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 32'(bus.CMD_READY), 32'd0);
      check("rst_busy", 32'(bus.BUSY), 32'd0);
      check("rst_res_valid", 32'(bus.RES_VALID), 32'd0);
      check("rst_alu_a", 32'(bus.ALU_A), 32'd0);
      check("rst_done_cnt", 32'(bus.DONE_CNT), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_cmd_ready", 32'(bus.CMD_READY), 32'd1);

      // Vector table; the CNT_W=2 twin walks 1,2,3,0,1,2.
      for (int i = 0; i < 6; i++)
         run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].bp, vecs[i].z, vecs[i].err);

      // Backpressure with a second command waiting until the handshake.
      bus.RES_READY = 1'b0;
      start_cmd(4'h2, 8'h33, 8'h11, 1'b0, 8'h22, 1'b0);
      wait_result();
      drive(4'h3, 8'h77, 8'h01, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(bus.RES_VALID), 32'd1);
         check("hold_z", 32'(bus.RES_Z), 32'h22);
         check("hold_ready", 32'(bus.CMD_READY), 32'd0);
         check("hold_alu_a", 32'(bus.ALU_A), 32'h33);
      end
      finish_cmd();
      exp_op = 4'h3; exp_a = 8'h77; exp_b = 8'h01; exp_z = 8'h76; exp_err = 1'b0;
      accept_check();
      wait_result();
      finish_cmd();

      // Asynchronous reset during SETTLE.
      bus.RES_READY = 1'b0;
      start_cmd(4'h3, 8'h12, 8'h34, 1'b0, 8'h26, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(bus.BUSY), 32'd0);
      check("mid_rst_ready", 32'(bus.CMD_READY), 32'd0);
      check("mid_rst_alu_a", 32'(bus.ALU_A), 32'd0);
      check("mid_rst_done", 32'(bus.DONE_CNT), 32'd0);
      model_cnt = 0;
      last_z = 8'h00;
      repeat (2) begin
         @(negedge clk);
         check("mid_rst_valid", 32'(bus.RES_VALID), 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_valid", 32'(bus.RES_VALID), 32'd0);
      run_cmd(4'h4, 8'h12, 8'h21, 1'b0, 0, 8'h33, 1'b0);

`ifdef ALU_CHAIN_EN
      run_cmd(4'h0, 8'h0F, 8'hF0, 1'b0, 0, 8'hFF, 1'b0);
      run_cmd(4'h5, 8'h01, 8'h77, 1'b1, 0, 8'hFE, 1'b0);
`endif

      // Randomized traffic against the reference.
      for (int i = 0; i < 40; i++) begin
         logic [3:0] op;
         logic [7:0] a, b;
         logic       chain;
         logic [8:0] r;
         int         bp;
         op    = 4'($urandom_range(0, 15));
         a     = 8'($urandom);
         b     = 8'($urandom);
         chain = 1'($urandom_range(0, 1));
         bp    = $urandom_range(0, 3);
         r     = ref_result(op, a, eff_b(b, chain));
         run_cmd(op, a, b, chain, bp, r[7:0], r[8]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream stage feeding custom_alu: accepts one command (opcode plus two operands) over a valid/ready handshake and registers it onto the ALU's OP/A/B inputs.
- Holds those inputs stable for a fixed settle time, then captures the ALU's combinational Z into a result register.
- Presents the result downstream over a second valid/ready handshake.
- Flags opcodes outside the ALU's defined range (0000–1001) and counts completed commands.

Parameters:
- WIDTH, 8: operand/result width; matches ALU A/B/Z.
- OPW, 4: opcode width; matches ALU OP.
- NUM_OPS, 10: opcodes 0..NUM_OPS-1 are legal; all others are illegal.
- SETTLE_CYCLES, 1: cycles ALU inputs are held before Z is sampled; legal range 1..15.
- CNT_W, 16: width of the completed-command counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  OPW  opcode.
- CMD_A  in  WIDTH  operand A.
- CMD_B  in  WIDTH  operand B.
- ALU_OP  out  OPW  registered opcode to ALU OP.
- ALU_A  out  WIDTH  registered operand to ALU A.
- ALU_B  out  WIDTH  registered operand to ALU B.
- ALU_Z  in  WIDTH  ALU result (combinational from ALU_OP/A/B).
- RES_VALID  out  1  result available.
- RES_READY  in  1  downstream accepts result.
- RES_Z  out  WIDTH  captured result.
- RES_OP  out  OPW  opcode that produced RES_Z.
- RES_ERR  out  1  opcode was illegal.
- BUSY  out  1  high whenever state is not IDLE.
- DONE_CNT  out  CNT_W  number of results handed off.

Behaviour:
- Reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: state=IDLE; ALU_OP/ALU_A/ALU_B=0; RES_VALID=0; RES_Z=0; RES_OP=0; RES_ERR=0; DONE_CNT=0; BUSY=0; CMD_READY=0 while rst is high.
- CMD_READY = (state==IDLE) && !rst.
- States:
  - IDLE: on CMD_VALID&&CMD_READY at edge k, register CMD_OP/A/B onto ALU_OP/A/B, latch the illegal flag (CMD_OP >= NUM_OPS), load settle counter with SETTLE_CYCLES, go to SETTLE.
  - SETTLE: ALU_* held constant. Counter decrements each edge. On the edge where the counter reaches 0 (edge k+SETTLE_CYCLES): RES_Z <= illegal ? 0 : ALU_Z; RES_OP <= ALU_OP; RES_ERR <= illegal; RES_VALID <= 1; go to RESULT.
  - RESULT: RES_* held stable while RES_VALID&&!RES_READY. On RES_VALID&&RES_READY: RES_VALID <= 0, DONE_CNT <= DONE_CNT+1, go to IDLE. CMD_READY is high the following cycle.
- Latency: accept at edge k -> RES_VALID high after edge k+SETTLE_CYCLES.
- Minimum command spacing: SETTLE_CYCLES+2 cycles.
- Illegal opcodes: ALU_OP is still driven with the raw opcode; RES_Z forced to 0; latency is identical to a legal opcode.
- CMD_VALID outside IDLE is ignored; the command is not consumed (CMD_READY=0).
- RES_READY outside RESULT has no effect.
- DONE_CNT wraps from 2^CNT_W-1 to 0 with no flag. It increments for both legal and illegal results.
- Reset mid-operation (SETTLE or RESULT): in-flight command is discarded, all outputs return to reset values immediately, nothing is counted.
- RES_VALID never drops without a handshake, except on reset.

Optional Feature:
- Macro: ALU_CHAIN_EN.
- Defined:
  - Adds input port CMD_CHAIN (1 bit) and an internal LAST_Z register (WIDTH bits, reset 0).
  - LAST_Z is updated with RES_Z at each result handshake where RES_ERR=0.
  - On accept with CMD_CHAIN=1, ALU_B <= LAST_Z instead of CMD_B; CMD_A is used as normal.
  - Errored results do not update LAST_Z.
- Undefined: no CMD_CHAIN port, no LAST_Z register; ALU_B always comes from CMD_B.

Test Plan:
- Bench stub ALU_Z = ALU_A ^ ALU_B. After rst falls, CMD_OP=0001, A=8'hF0, B=8'h0F, RES_READY=1 -> RES_VALID high exactly 1 edge after accept; RES_Z=8'hFF, RES_OP=0001, RES_ERR=0, DONE_CNT=1.
- CMD_OP=1100, A=8'h55, B=8'hAA -> RES_Z=8'h00, RES_ERR=1, same latency; DONE_CNT increments.
- Backpressure: hold RES_READY=0 for 5 cycles -> RES_VALID/RES_Z stable, CMD_READY=0 throughout, second CMD_VALID not consumed; raise RES_READY -> handshake, then second command accepted the next cycle.
- Assert rst during SETTLE (after accept of A=8'h12) -> outputs reset asynchronously; RES_VALID never rises; DONE_CNT=0; next command completes normally.
- CNT_W=2 build: 5 commands -> DONE_CNT sequence 1,2,3,0,1.
- With ALU_CHAIN_EN: cmd A=8'h0F, B=8'hF0 (Z=8'hFF), then CMD_CHAIN=1, A=8'h01, B=8'h77 -> ALU_B=8'hFF, RES_Z=8'hFE.
